// File: rtl/dcm_prog_ctrl.sv
// Button/switch front-end for the clock manager: synchronise, debounce, issue one update per press.
// Optional WAIT_ACK timeout is enabled by defining DCM_PROG_CTRL_ACK_TIMEOUT_EN.
module dcm_prog_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACK_TIMEOUT     = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_update,
    input  logic [2:0] sw_prog,
    input  logic [2:0] prog_out,
    output logic       update,
    output logic [2:0] prog_in,
    output logic       busy,
    output logic       ack_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        ISSUE,
        WAIT_ACK,
        RELEASE
    } state_t;

    // Out-of-range parameters leave this marker scope in the elaborated hierarchy.
    generate
        if (DEBOUNCE_CYCLES < 2 || ACK_TIMEOUT < 2) begin : g_param_range_invalid
        end
    endgenerate

    logic       btn_meta_q, btn_s_q;
    logic [2:0] sw_meta_q, sw_s_q;
    logic [2:0] po_meta_q, po_s_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       prog_q, prog_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta_q <= 1'b0;
            btn_s_q    <= 1'b0;
            sw_meta_q  <= 3'd0;
            sw_s_q     <= 3'd0;
            po_meta_q  <= 3'd0;
            po_s_q     <= 3'd0;
        end else begin
            btn_meta_q <= btn_update;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= sw_prog;
            sw_s_q     <= sw_meta_q;
            po_meta_q  <= prog_out;
            po_s_q     <= po_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prog_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prog_q  <= prog_d;
        end
    end

`ifdef DCM_PROG_CTRL_ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prog_d  = prog_q;
        update  = 1'b0;
        busy    = 1'b0;
        ack_err = 1'b0;
`ifdef DCM_PROG_CTRL_ACK_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // The only point where a new program value is captured.
                    prog_d  = sw_s_q;
                    cnt_d   = '0;
                    state_d = (sw_s_q == po_s_q) ? RELEASE : ISSUE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                update  = 1'b1;
                busy    = 1'b1;
                state_d = WAIT_ACK;
`ifdef DCM_PROG_CTRL_ACK_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (po_s_q == prog_q) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef DCM_PROG_CTRL_ACK_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    // Give up: report, and mirror what the clock manager actually runs.
                    ack_err = 1'b1;
                    prog_d  = po_s_q;
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (btn_s_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign prog_in = prog_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Scoreboard bench for dcm_prog_ctrl (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=20).
module tb_dcm_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_update = 1'b0;
    logic [2:0] sw_prog = 3'd0;
    logic [2:0] prog_out = 3'd0;
    logic       update;
    logic [2:0] prog_in;
    logic       busy;
    logic       ack_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int upd_cyc = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    logic prev_update = 1'b0;
    logic [2:0] exp_q[$];

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .ACK_TIMEOUT(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_update(btn_update),
        .sw_prog(sw_prog),
        .prog_out(prog_out),
        .update(update),
        .prog_in(prog_in),
        .busy(busy),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every update pulse pops the value the stimulus expected to be issued.
    always @(negedge clk) begin
        if (rst) begin
            if (update) begin
                upd_cnt = upd_cnt + 1;
                upd_cyc = cyc;
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_update at cyc %0d: prog_in=%0d, no update expected", cyc, prog_in);
                end else begin
                    logic [2:0] exp_v;
                    exp_v = exp_q.pop_front();
                    if (prog_in !== exp_v) begin
                        failures = failures + 1;
                        $display("FAIL update_prog_in: got %0d expected %0d", prog_in, exp_v);
                    end
                    checks = checks + 1;
                    if (busy !== 1'b1) begin
                        failures = failures + 1;
                        $display("FAIL update_busy: got %b expected 1", busy);
                    end
                end
                checks = checks + 1;
                if (prev_update === 1'b1) begin
                    failures = failures + 1;
                    $display("FAIL update_consecutive: update high two cycles at cyc %0d", cyc);
                end
                checks = checks + 1;
                if (ack_err !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL update_with_ack_err: ack_err=%b expected 0", ack_err);
                end
                $display("txn update cyc=%0d prog_in=%0d", cyc, prog_in);
            end
            if (ack_err === 1'b1) begin
                err_cnt = err_cnt + 1;
                err_cyc = cyc;
                $display("txn ack_err cyc=%0d prog_in=%0d", cyc, prog_in);
            end
            prev_update = update;
        end else begin
            prev_update = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_update(input int start, input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            tick(1);
            if (upd_cnt != start) got = 1'b1;
        end
    endtask

    task automatic wait_not_busy(input int limit, output int n);
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic release_btn();
        btn_update = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        int c0;
        int start;
        bit got;
        tick(2);
        checks++; if (update !== 1'b0)  begin failures++; $display("FAIL reset_update: got %b expected 0", update); end
        checks++; if (prog_in !== 3'd0) begin failures++; $display("FAIL reset_prog_in: got %0d expected 0", prog_in); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL reset_ack_err: got %b expected 0", ack_err); end
        rst = 1'b1;
        sw_prog = 3'd7;
        prog_out = 3'd0;
        tick(3);
        // Reset asserted while the button is held mid-debounce.
        btn_update = 1'b1;
        start = upd_cnt;
        tick(4);
        #2 rst = 1'b0;
        #1;
        checks++; if (update !== 1'b0 || busy !== 1'b0 || prog_in !== 3'd0) begin
            failures++; $display("FAIL reset_mid_debounce: got upd=%b busy=%b prog=%0d expected 0/0/0", update, busy, prog_in);
        end
        tick(1);
        rst = 1'b1;
        c0 = cyc;
        exp_q.push_back(3'd7);
        wait_update(start, 30, got);
        checks++; if (!got) begin failures++; $display("FAIL reset_rearm_update: got none expected one update"); end
        checks++; if (upd_cyc - c0 !== 7) begin failures++; $display("FAIL reset_rearm_latency: got %0d expected 7", upd_cyc - c0); end
        checks++; if (upd_cnt - start !== 1) begin failures++; $display("FAIL reset_rearm_count: got %0d expected 1", upd_cnt - start); end
        // Reset while waiting for the acknowledge clears prog_in and busy at once.
        tick(2);
        #2 rst = 1'b0;
        #1;
        checks++; if (prog_in !== 3'd0 || busy !== 1'b0 || update !== 1'b0) begin
            failures++; $display("FAIL reset_mid_wait: got prog=%0d busy=%b upd=%b expected 0/0/0", prog_in, busy, update);
        end
        tick(1);
        btn_update = 1'b0;
        rst = 1'b1;
        tick(10);
        checks++; if (upd_cnt - start !== 1) begin failures++; $display("FAIL reset_no_extra: got %0d updates expected 1", upd_cnt - start); end
    endtask

    task automatic test_clean_press();
        int c0, start, n;
        bit got;
        sw_prog = 3'd5;
        prog_out = 3'd0;
        tick(4);
        start = upd_cnt;
        exp_q.push_back(3'd5);
        btn_update = 1'b1;
        c0 = cyc;
        wait_update(start, 30, got);
        checks++; if (!got) begin failures++; $display("FAIL clean_update: got none expected one"); end
        checks++; if (upd_cyc - c0 !== 7) begin failures++; $display("FAIL clean_latency: got %0d expected 7", upd_cyc - c0); end
        prog_out = 3'd5;
        wait_not_busy(8, n);
        checks++; if (n > 3 || busy !== 1'b0) begin failures++; $display("FAIL clean_ack: busy low after %0d cycles expected <= 3", n); end
        checks++; if (prog_in !== 3'd5) begin failures++; $display("FAIL clean_prog_in: got %0d expected 5", prog_in); end
        // Short release (too short to re-arm) followed by another press.
        tick(10);
        btn_update = 1'b0;
        tick(2);
        btn_update = 1'b1;
        tick(12);
        checks++; if (upd_cnt - start !== 1) begin failures++; $display("FAIL clean_no_retrigger: got %0d updates expected 1", upd_cnt - start); end
        release_btn();
    endtask

    task automatic test_bounce();
        int c0, start;
        bit got;
        logic pattern [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        sw_prog = 3'd6;
        prog_out = 3'd0;
        tick(4);
        start = upd_cnt;
        for (int i = 0; i < 6; i++) begin
            btn_update = pattern[i];
            tick(1);
        end
        tick(10);
        checks++; if (upd_cnt !== start) begin failures++; $display("FAIL bounce_rejected: got %0d updates expected 0", upd_cnt - start); end
        // A clean press afterwards must see full latency, showing the FSM is back in IDLE.
        exp_q.push_back(3'd6);
        btn_update = 1'b1;
        c0 = cyc;
        wait_update(start, 30, got);
        checks++; if (!got || upd_cyc - c0 !== 7) begin failures++; $display("FAIL bounce_then_press: got latency %0d expected 7", upd_cyc - c0); end
        prog_out = 3'd6;
        tick(5);
        release_btn();
    endtask

    task automatic test_noop();
        int start;
        bit busy_seen;
        sw_prog = 3'd2;
        prog_out = 3'd2;
        tick(4);
        start = upd_cnt;
        busy_seen = 1'b0;
        btn_update = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (busy === 1'b1) busy_seen = 1'b1;
        end
        checks++; if (upd_cnt !== start) begin failures++; $display("FAIL noop_update: got %0d updates expected 0", upd_cnt - start); end
        checks++; if (prog_in !== 3'd2) begin failures++; $display("FAIL noop_prog_in: got %0d expected 2", prog_in); end
        checks++; if (busy_seen) begin failures++; $display("FAIL noop_busy: got busy high expected 0"); end
        release_btn();
    endtask

    task automatic test_hold_switch();
        int start, n;
        bit got;
        sw_prog = 3'd3;
        prog_out = 3'd2;
        tick(4);
        start = upd_cnt;
        exp_q.push_back(3'd3);
        btn_update = 1'b1;
        wait_update(start, 30, got);
        checks++; if (!got) begin failures++; $display("FAIL hold_update: got none expected one"); end
        prog_out = 3'd3;
        wait_not_busy(8, n);
        for (int i = 0; i < 100; i++) begin
            if (i == 20) sw_prog = 3'd6;
            tick(1);
        end
        checks++; if (upd_cnt - start !== 1) begin failures++; $display("FAIL hold_no_second: got %0d updates expected 1", upd_cnt - start); end
        checks++; if (prog_in !== 3'd3) begin failures++; $display("FAIL hold_prog_in: got %0d expected 3", prog_in); end
        release_btn();
    endtask

    task automatic test_timeout();
        int start, e0;
        bit got;
        sw_prog = 3'd4;
        prog_out = 3'd1;
        tick(4);
        start = upd_cnt;
        e0 = err_cnt;
        exp_q.push_back(3'd4);
        btn_update = 1'b1;
        wait_update(start, 30, got);
        checks++; if (!got) begin failures++; $display("FAIL timeout_update: got none expected one"); end
`ifdef DCM_PROG_CTRL_ACK_TIMEOUT_EN
        for (int i = 0; i < 40 && err_cnt == e0; i++) tick(1);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_ack_err: got %0d pulses expected 1", err_cnt - e0); end
        checks++; if (err_cyc - upd_cyc !== 20) begin failures++; $display("FAIL timeout_delay: got %0d expected 20", err_cyc - upd_cyc); end
        tick(1);
        checks++; if (ack_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_width: got %b expected 0", ack_err); end
        checks++; if (prog_in !== 3'd1) begin failures++; $display("FAIL timeout_prog_in: got %0d expected 1", prog_in); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        release_btn();
`else
        tick(60);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL notimeout_busy: got %b expected 1", busy); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL notimeout_ack_err: got %0d pulses expected 0", err_cnt - e0); end
        checks++; if (prog_in !== 3'd4) begin failures++; $display("FAIL notimeout_prog_in: got %0d expected 4", prog_in); end
        prog_out = 3'd4;
        tick(5);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL notimeout_late_ack: got busy %b expected 0", busy); end
        release_btn();
`endif
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_noop();
        test_hold_switch();
        test_timeout();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
